// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler: weighted round-robin drain of four VC ingress FIFOs into one downstream FIFO.
// Define QOS_STRICT_VC0_EN to give VC0 strict priority ahead of the WRR rotation.
module qos_wrr_scheduler #(
    parameter int unsigned WEIGHT_W   = 3,
    parameter int unsigned RST_WEIGHT = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                cfg_wr_i,
    input  logic [1:0]          cfg_vc_i,
    input  logic [WEIGHT_W-1:0] cfg_weight_i,
    input  logic [3:0]          empty_i,
    input  logic [3:0]          pause_stb_i,
    input  logic [3:0]          continue_stb_i,
    input  logic                out_full_i,
    output logic [3:0]          pop_o,
    output logic                push_o,
    output logic [1:0]          grant_id_o,
    output logic [3:0]          paused_o,
    output logic                idle_o
);
    localparam int unsigned NUM_VC = 4;
    localparam int unsigned VC_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_GRANT  = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [VC_W-1:0]                 ptr_q, ptr_d;
    logic [NUM_VC-1:0][WEIGHT_W-1:0] weight_q, weight_d;
    logic [NUM_VC-1:0][WEIGHT_W-1:0] credit_q, credit_d;
    logic [NUM_VC-1:0]               paused_q, paused_d;
    logic                            push_q, push_d;
    logic [VC_W-1:0]                 grant_id_q, grant_id_d;

    logic [NUM_VC-1:0] ready;
    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] refill_req;
    logic [NUM_VC-1:0] pop;
    logic [VC_W-1:0]   grant;
    logic              grant_vld;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            ready[i] = !empty_i[i] && !paused_q[i] && (weight_q[i] != '0);
            elig[i]  = ready[i] && (credit_q[i] != '0);
        end
    end

    // A strict-priority VC0 is always served directly, so it never asks for a refill.
`ifdef QOS_STRICT_VC0_EN
    assign refill_req = ready & 4'b1110;
`else
    assign refill_req = ready;
`endif

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (!grant_vld && elig[ptr_q + VC_W'(k)]) begin
                grant     = ptr_q + VC_W'(k);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        pop      = '0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (|ready)) state_d = S_REFILL;
            end
            S_REFILL: begin
                credit_d = weight_q;
                state_d  = enable_i ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
`ifdef QOS_STRICT_VC0_EN
                end else if (ready[0] && !out_full_i) begin
                    pop[0] = 1'b1;
`endif
                end else if (grant_vld && !out_full_i) begin
                    pop[grant]      = 1'b1;
                    credit_d[grant] = credit_q[grant] - WEIGHT_W'(1);
                    // Stay on the granted VC until its last credit is spent.
                    ptr_d = (credit_q[grant] == WEIGHT_W'(1)) ? grant + VC_W'(1) : grant;
                end else if (out_full_i) begin
                    state_d = S_GRANT;
                end else if (|refill_req) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset_i) pop = '0;
    end

    always_comb begin
        weight_d = weight_q;
        if (cfg_wr_i) weight_d[cfg_vc_i] = cfg_weight_i;
        paused_d   = (paused_q & ~continue_stb_i) | pause_stb_i;
        push_d     = |pop;
        grant_id_d = grant_id_q;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pop[i]) grant_id_d = VC_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            weight_q   <= {NUM_VC{WEIGHT_W'(RST_WEIGHT)}};
            credit_q   <= {NUM_VC{WEIGHT_W'(RST_WEIGHT)}};
            paused_q   <= '0;
            push_q     <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            weight_q   <= weight_d;
            credit_q   <= credit_d;
            paused_q   <= paused_d;
            push_q     <= push_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign pop_o      = pop;
    assign push_o     = push_q;
    assign grant_id_o = grant_id_q;
    assign paused_o   = paused_q;
    assign idle_o     = (state_q == S_IDLE);

endmodule
